// File: rtl/message_serializer.sv
// Buffers LSB-aligned message words of up to 32 bytes and streams them out as
// 64-bit beats, first byte in the MSBs, with sop/eop/empty framing.
module message_serializer #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  input  logic [31:0]  in_bytemask,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [63:0]  out_data,
  output logic         out_startofpacket,
  output logic         out_endofpacket,
  output logic [2:0]   out_empty,
  output logic [15:0]  msg_cnt,
  output logic [15:0]  drop_cnt
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;

  typedef enum logic {
    StIdle,
    StSend
  } state_e;

  state_e state_q, state_d;

  logic [255:0]    fifo_data_q [FIFO_DEPTH];
  logic [5:0]      fifo_len_q  [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;

  logic [255:0] shreg_q, shreg_d;
  logic [2:0]   beats_left_q, beats_left_d;
  logic [2:0]   empty_q, empty_d;
  logic         first_q, first_d;
  logic [15:0]  msg_cnt_q, msg_cnt_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;

  logic [5:0]   in_len;
  logic         accept, push, drop, pop, load, fifo_empty;
  logic         beat_fire, eop_fire;
  logic [255:0] head_data;
  logic [5:0]   head_len;
  logic [5:0]   head_len_p7;
  logic [5:0]   head_shift;

  // Highest set mask bit defines the length; lower zero bits still count as valid bytes.
  always_comb begin
    in_len = 6'd0;
    for (int k = 0; k < 32; k++) begin
      if (in_bytemask[k]) begin
        in_len = 6'(k + 1);
      end
    end
  end

  assign in_ready   = (occ_q < OccW'(FIFO_DEPTH));
  assign fifo_empty = (occ_q == '0);
  assign accept     = in_valid && in_ready;
  assign push       = accept && (in_bytemask != 32'd0);
  assign drop       = accept && (in_bytemask == 32'd0);

  assign head_data   = fifo_data_q[rd_ptr_q];
  assign head_len    = fifo_len_q[rd_ptr_q];
  assign head_len_p7 = head_len + 6'd7;
  assign head_shift  = 6'd32 - head_len;

  assign beat_fire = (state_q == StSend) && out_ready;
  assign eop_fire  = beat_fire && (beats_left_q == 3'd1);

  // FSM: an eop transfer reloads from the FIFO in the same cycle when it can.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (eop_fire) begin
          if (!fifo_empty) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shreg_d      = shreg_q;
    beats_left_d = beats_left_q;
    empty_d      = empty_q;
    first_d      = first_q;
    if (load) begin
      shreg_d      = head_data << {head_shift, 3'b000};
      beats_left_d = head_len_p7[5:3];
      empty_d      = 3'd0 - head_len[2:0];
      first_d      = 1'b1;
    end else if (beat_fire) begin
      shreg_d      = {shreg_q[191:0], 64'd0};
      beats_left_d = beats_left_q - 3'd1;
      first_d      = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    msg_cnt_d  = msg_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (eop_fire) begin
      msg_cnt_d = msg_cnt_q + 16'd1;
    end
    if (drop) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      shreg_q      <= '0;
      beats_left_q <= '0;
      empty_q      <= '0;
      first_q      <= 1'b0;
      msg_cnt_q    <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      shreg_q      <= shreg_d;
      beats_left_q <= beats_left_d;
      empty_q      <= empty_d;
      first_q      <= first_d;
      msg_cnt_q    <= msg_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage array needs no reset: occupancy guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= in_data;
      fifo_len_q[wr_ptr_q]  <= in_len;
    end
  end

  assign out_valid         = (state_q == StSend);
  assign out_data          = out_valid ? shreg_q[255:192] : 64'd0;
  assign out_startofpacket = out_valid && first_q;
  assign out_endofpacket   = out_valid && (beats_left_q == 3'd1);
  assign out_empty         = out_endofpacket ? empty_q : 3'd0;
  assign msg_cnt           = msg_cnt_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: doc/message_serializer.md
MESSAGE_SERIALIZER -- requirements
Module: message_serializer

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 2, message-entry buffer depth; legal values 2, 4, 8.
REQ-002 SHALL have port clk  input  1  clock; all sequential logic updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  message word valid from the message extractor.
REQ-005 SHALL have port in_ready  output  1  block can accept a message word.
REQ-006 SHALL have port in_data  input  256  message payload, LSB-aligned; last byte is in bits [7:0].
REQ-007 SHALL have port in_bytemask  input  32  valid-byte mask; bit k covers in_data[8k+7:8k].
REQ-008 SHALL have port out_ready  input  1  downstream accepts the current beat.
REQ-009 SHALL have port out_valid  output  1  beat valid.
REQ-010 SHALL have port out_data  output  64  beat data; first byte in [63:56].
REQ-011 SHALL have port out_startofpacket  output  1  first beat of a message.
REQ-012 SHALL have port out_endofpacket  output  1  last beat of a message.
REQ-013 SHALL have port out_empty  output  3  unused low-order bytes in an eop beat; 0 otherwise.
REQ-014 SHALL have port msg_cnt  output  16  count of messages completed on the output.
REQ-015 SHALL have port drop_cnt  output  16  count of zero-mask words discarded.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready.
- in_ready = (FIFO occupancy < FIFO_DEPTH), decoded from registered occupancy only.
- No combinational path from out_ready to in_ready.
REQ-017 Message length N (1..32) SHALL be the index of the highest set bit of in_bytemask plus 1.
- Lower zero bits do not shorten the message; those bytes are treated as valid.
- N SHALL be stored with the data as a 6-bit field.
REQ-018 An accepted word with in_bytemask == 0 SHALL NOT be written to the FIFO and SHALL increment drop_cnt.
REQ-019 The FIFO SHALL be circular with FIFO_DEPTH entries.
- Simultaneous push and pop SHALL leave occupancy unchanged.
- Write and read pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 The FSM SHALL have two states, IDLE and SEND.
- IDLE -> SEND when the FIFO is non-empty: pop head; load shift register with in_data << 8*(32-N); beats_left = ceil(N/8).
REQ-021 In SEND, output beat fields SHALL be:
- out_valid = 1.
- out_data = shift register [255:192].
- out_startofpacket = 1 on the first beat only.
- out_endofpacket = 1 when beats_left == 1.
- out_empty = 8*ceil(N/8) - N on the eop beat, 0 otherwise.
REQ-022 On out_valid && out_ready, the shift register SHALL shift left 64 (zero fill) and beats_left SHALL decrement.
REQ-023 On the eop transfer, the FSM SHALL either:
- load the next FIFO head in the same cycle if one is present, giving back-to-back packets with no idle cycle; or
- return to IDLE with out_valid = 0.
REQ-024 While out_valid && !out_ready, all out_* signals SHALL hold stable.
REQ-025 Latency SHALL be 2 cycles: a word accepted at edge T into an empty, idle block gives out_valid high after edge T+1.
REQ-026 Padding bytes in the eop beat SHALL be zero.
REQ-027 msg_cnt SHALL increment on each eop transfer and wrap 0xFFFF -> 0.
REQ-028 drop_cnt SHALL wrap 0xFFFF -> 0.
REQ-029 Throughput SHALL be one beat per cycle while out_ready is held high.

Reset
REQ-030 On reset_n low, the block SHALL immediately clear the following:
- FSM = IDLE; FIFO occupancy and pointers = 0.
- out_valid = out_startofpacket = out_endofpacket = 0; out_data = 0; out_empty = 0.
- msg_cnt = drop_cnt = 0.
REQ-031 in_ready SHALL be 1 from the first clock edge after reset deassertion.
REQ-032 Reset mid-packet SHALL abandon the packet, with no eop emitted and buffered messages discarded.

Verification
REQ-033 Single 12-byte message, mask 0x00000FFF, data bytes 0x0B..0x00 in [95:0], out_ready = 1 -> exactly 2 beats, with no idle cycle between them:
- beat 1: 0x0B0A090807060504, sop = 1.
- beat 2: 0x0302010000000000, eop = 1, empty = 4.
- msg_cnt = 1.
REQ-034 N = 1 (mask 0x1, byte 0xAA) -> one beat 0xAA00000000000000, sop = eop = 1, empty = 7.
REQ-035 N = 32 (full mask) -> 4 beats, empty = 0, sop on beat 1, eop on beat 4.
REQ-036 out_ready = 0 with 3 messages offered and FIFO_DEPTH = 2 -> backpressure behaviour:
- in_ready = 0 after 2 accepted FIFO entries plus 1 in SEND.
- out_* held stable throughout.
- After out_ready = 1, all 3 messages are emitted in order, back-to-back.
REQ-037 Zero mask word -> nothing emitted, drop_cnt = 1, in_ready stays 1.
REQ-038 reset_n pulsed low during beat 2 of a 24-byte message -> out_valid = 0 immediately, msg_cnt = 0, no eop seen, next message is emitted normally.
